// File: rtl/ad_adc_deser_align.sv
// ad_adc_deser_align: 2-bit-per-clock ADC deserializer with frame-clock bit-slip alignment
module ad_adc_deser_align #(
  parameter int DATA_WIDTH = 12,
  parameter int CH_NUM     = 8,
  parameter int LOCK_CNT   = 4,
  parameter int MISS_MAX   = 2
) (
  input  logic                           CLKR,
  input  logic                           RST_N,
  input  logic [1:0]                     FC_PAIR,
  input  logic [2*CH_NUM-1:0]            DD_PAIR,
  input  logic                           REALIGN,
  output logic                           ENB,
  output logic [CH_NUM*DATA_WIDTH-1:0]   DATA,
  output logic                           LOCKED,
  output logic [3:0]                     BIT_OFS,
  output logic                           FRAME_ERR,
  output logic [15:0]                    ERR_CNT
);
  localparam int WW = 2 * DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam logic [DATA_WIDTH-1:0] FC_WORD = {{HW{1'b1}}, {HW{1'b0}}};
  typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] fc_w;
  logic [WW-1:0] dd_w [CH_NUM];
  logic [3:0] phase, match_cnt, miss_cnt, match_nxt, miss_nxt, ofs_nxt, ofs_inc;
  logic [15:0] err_nxt;
  logic ferr_nxt, load, ws, match;
  logic [DATA_WIDTH-1:0] fc_word;
  logic [CH_NUM*DATA_WIDTH-1:0] lane_words;
  assign ws      = phase == 4'(HW - 1);
  assign fc_word = DATA_WIDTH'(fc_w >> BIT_OFS);
  assign match   = fc_word == FC_WORD;
  assign ofs_inc = BIT_OFS == 4'(DATA_WIDTH - 1) ? 4'd0 : BIT_OFS + 4'd1;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
    always_ff @(posedge CLKR)
      dd_w[i] <= !RST_N ? '0 : {dd_w[i][WW-3:0], DD_PAIR[2*i+1], DD_PAIR[2*i]};
    assign lane_words[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(dd_w[i] >> BIT_OFS);
  end
  // Decisions happen only on the word strobe; REALIGN overrides everything.
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    ofs_nxt   = BIT_OFS;
    err_nxt   = ERR_CNT;
    ferr_nxt  = FRAME_ERR;
    load      = 1'b0;
    if (REALIGN) begin
      state_nxt = S_SEARCH;
      match_nxt = '0;
      miss_nxt  = '0;
    end else if (ws) begin
      case (state)
        S_SEARCH: begin
          if (match) begin
            state_nxt = LOCK_CNT == 1 ? S_LOCKED : S_VERIFY;
            match_nxt = 4'd1;
          end else ofs_nxt = ofs_inc;
        end
        S_VERIFY: begin
          if (match) begin
            match_nxt = match_cnt + 4'd1;
            state_nxt = match_nxt == 4'(LOCK_CNT) ? S_LOCKED : S_VERIFY;
          end else begin
            state_nxt = S_SEARCH;
            match_nxt = '0;
            ofs_nxt   = ofs_inc;
          end
        end
        default: begin
          load = 1'b1;
          if (match) miss_nxt = '0;
          else begin
            err_nxt  = ERR_CNT == 16'hFFFF ? ERR_CNT : ERR_CNT + 16'd1;
            miss_nxt = miss_cnt + 4'd1;
            if (miss_nxt == 4'(MISS_MAX)) begin
              state_nxt = S_SEARCH;
              ferr_nxt  = 1'b1;
              miss_nxt  = '0;
              match_nxt = '0;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge CLKR) begin
    if (!RST_N) begin
      state     <= S_SEARCH;
      phase     <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      BIT_OFS   <= '0;
      fc_w      <= '0;
      ENB       <= 1'b0;
      DATA      <= '0;
      LOCKED    <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= ws ? 4'd0 : phase + 4'd1;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      BIT_OFS   <= ofs_nxt;
      fc_w      <= {fc_w[WW-3:0], FC_PAIR};
      ENB       <= load;
      if (load) DATA <= lane_words;
      LOCKED    <= state_nxt == S_LOCKED;
      FRAME_ERR <= ferr_nxt;
      ERR_CNT   <= err_nxt;
    end
  end
endmodule

// File: tb/tb_ad_adc_deser_align.sv
// tb_ad_adc_deser_align: random-data bench against a bit-history reference model
module tb_ad_adc_deser_align;
  localparam int DW = 12, CH = 8, HW = DW / 2, LOCK_N = 4, MISS_N = 2;
  localparam logic [DW-1:0] FC = 12'hFC0;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, realign, enb, locked, frame_err;
  logic [1:0] fc_pair;
  logic [2*CH-1:0] dd_pair;
  logic [CH*DW-1:0] data;
  logic [3:0] bit_ofs;
  logic [15:0] err_cnt;

  ad_adc_deser_align #(.DATA_WIDTH(DW), .CH_NUM(CH), .LOCK_CNT(LOCK_N), .MISS_MAX(MISS_N)) dut (
    .CLKR(clk), .RST_N(rst_n), .FC_PAIR(fc_pair), .DD_PAIR(dd_pair), .REALIGN(realign),
    .ENB(enb), .DATA(data), .LOCKED(locked), .BIT_OFS(bit_ofs), .FRAME_ERR(frame_err),
    .ERR_CNT(err_cnt)
  );

  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream generator: frames of DW bits, MSB first, delayed by d bit times.
  int d, bpos, corrupt_n;
  logic [DW-1:0] cur_fc;
  logic [DW-1:0] cur_ln [CH];
  logic [DW-1:0] lane_val [CH];
  logic [CH*DW-1:0] exp_data;

  task automatic gen_restart();
    bpos = ((2 - d) % DW + DW) % DW;
    cur_fc = FC;
    cur_ln = lane_val;
  endtask

  task automatic gen_bit(output logic [CH:0] b);
    if (bpos == 0) begin
      cur_fc = corrupt_n > 0 ? FC ^ 12'h021 : FC;
      if (corrupt_n > 0) corrupt_n--;
      cur_ln = lane_val;
    end
    b[CH] = cur_fc[DW-1-bpos];
    for (int c = 0; c < CH; c++) b[c] = cur_ln[c][DW-1-bpos];
    bpos = (bpos + 1) % DW;
  endtask

  // Reference model: keeps the received bits as a history (index 0 = newest)
  // and applies the alignment rules frame by frame.
  int m_st, m_ofs, m_mc, m_ms, m_phase;
  int unsigned m_err;
  logic m_ferr, m_enb;
  logic [CH*DW-1:0] m_data;
  logic [CH:0] hist [$];

  function automatic logic [DW-1:0] word_at(int c);
    logic [DW-1:0] w;
    for (int j = 0; j < DW; j++) w[j] = (m_ofs + j < hist.size()) ? hist[m_ofs+j][c] : 1'b0;
    return w;
  endfunction

  task automatic model_step();
    logic hit;
    m_enb = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_ofs = 0; m_mc = 0; m_ms = 0; m_phase = 0; m_err = 0;
      m_ferr = 1'b0; m_data = '0;
      hist.delete();
    end else begin
      if (realign) begin
        m_st = 0; m_mc = 0; m_ms = 0;
      end else if (m_phase == HW - 1) begin
        hit = word_at(CH) == FC;
        if (m_st == 2) begin
          m_enb = 1'b1;
          for (int c = 0; c < CH; c++) m_data[c*DW +: DW] = word_at(c);
          if (hit) m_ms = 0;
          else begin
            if (m_err < 65535) m_err++;
            m_ms++;
            if (m_ms >= MISS_N) begin
              m_st = 0; m_ms = 0; m_mc = 0; m_ferr = 1'b1;
            end
          end
        end else if (hit) begin
          m_mc++;
          m_st = m_mc >= LOCK_N ? 2 : 1;
        end else begin
          m_st = 0; m_mc = 0; m_ofs = (m_ofs + 1) % DW;
        end
      end
      m_phase = (m_phase + 1) % HW;
      hist.push_front({fc_pair[1], dd_pair[15], dd_pair[13], dd_pair[11], dd_pair[9],
                       dd_pair[7], dd_pair[5], dd_pair[3], dd_pair[1]});
      hist.push_front({fc_pair[0], dd_pair[14], dd_pair[12], dd_pair[10], dd_pair[8],
                       dd_pair[6], dd_pair[4], dd_pair[2], dd_pair[0]});
      while (hist.size() > 2 * DW) void'(hist.pop_back());
    end
  endtask

  task automatic tick();
    logic [CH:0] b1, b0;
    if (rst_n) begin
      gen_bit(b1);
      gen_bit(b0);
      fc_pair = {b1[CH], b0[CH]};
      for (int c = 0; c < CH; c++) dd_pair[2*c +: 2] = {b1[c], b0[c]};
    end else begin
      fc_pair = '0;
      dd_pair = '0;
      gen_restart();
    end
    @(posedge clk);
    model_step();
    #1;
    check("enb", enb, m_enb);
    check("data", data, m_data);
    check("locked", locked, m_st == 2);
    check("bit_ofs", bit_ofs, m_ofs);
    check("frame_err", frame_err, m_ferr);
    check("err_cnt", err_cnt, m_err);
    realign = 1'b0;
  endtask

  task automatic wait_locked(input string tag, output int enb_seen);
    int n = 0;
    enb_seen = 0;
    while (!locked && n < 400) begin
      tick();
      if (enb && !locked) enb_seen++;
      n++;
    end
    check({tag, "_lock"}, locked, 1'b1);
  endtask

  task automatic wait_enb(input string tag);
    int n = 0;
    while (!enb && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_enb"}, enb, 1'b1);
  endtask

  task automatic set_lanes(input logic rnd);
    for (int c = 0; c < CH; c++) begin
      lane_val[c] = rnd ? DW'($urandom) : DW'(12'h100 + c);
      exp_data[c*DW +: DW] = lane_val[c];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pre, last, cyc, ofs0;
    logic [15:0] err0;
    rst_n = 1'b0; realign = 1'b0; fc_pair = '0; dd_pair = '0;
    d = 0; corrupt_n = 0;
    set_lanes(1'b0);
    repeat (3) tick();
    check("rst_locked", locked, 1'b0);
    check("rst_err_cnt", err_cnt, 16'h0);
    rst_n = 1'b1;
    // Aligned stream, fixed lane values
    wait_locked("t1", pre);
    check("t1_enb_pre_lock", pre, 0);
    check("t1_ofs", bit_ofs, 4'd0);
    last = -1;
    cyc = 0;
    repeat (40) begin
      tick();
      cyc++;
      if (enb) begin
        if (last >= 0) check("t1_gap", cyc - last, 6);
        check("t1_data", data, exp_data);
        last = cyc;
      end
    end
    // REALIGN on a word-strobe cycle
    ofs0 = bit_ofs;
    err0 = err_cnt;
    while (m_phase != HW - 1) tick();
    realign = 1'b1;
    tick();
    check("ra_locked", locked, 1'b0);
    check("ra_frame_err", frame_err, 1'b0);
    check("ra_err_cnt", err_cnt, err0);
    wait_locked("ra", pre);
    check("ra_ofs", bit_ofs, ofs0);
    // Single then double corrupted frame clock
    set_lanes(1'b1);
    corrupt_n = 1;
    repeat (30) tick();
    check("c1_err_cnt", err_cnt, 16'd1);
    check("c1_locked", locked, 1'b1);
    corrupt_n = 2;
    for (int n = 0; n < 40 && locked; n++) tick();
    check("c2_locked", locked, 1'b0);
    check("c2_frame_err", frame_err, 1'b1);
    check("c2_err_cnt", err_cnt, 16'd3);
    wait_locked("c2", pre);
    // Error counter saturation
    force dut.ERR_CNT = 16'hFFFF;
    m_err = 65535;
    tick();
    release dut.ERR_CNT;
    tick();
    corrupt_n = 1;
    repeat (30) tick();
    check("sat_err_cnt", err_cnt, 16'hFFFF);
    check("sat_locked", locked, 1'b1);
    // One-cycle reset mid-frame, then reacquire a stream delayed by 5 bits
    while (m_phase != 2) tick();
    d = 5;
    set_lanes(1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_enb", enb, 1'b0);
    check("mr_data", data, '0);
    check("mr_locked", locked, 1'b0);
    check("mr_ofs", bit_ofs, 4'd0);
    check("mr_frame_err", frame_err, 1'b0);
    check("mr_err_cnt", err_cnt, 16'd0);
    wait_locked("t2", pre);
    check("t2_enb_pre_lock", pre, 0);
    check("t2_ofs", bit_ofs, 4'((DW - d) % DW));
    wait_enb("t2");
    check("t2_data", data, exp_data);
    repeat (12) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
